// File: rtl/gpio_shift_out.sv
// gpio_shift_out: mirrors a parallel word onto a 74HC595-style chain over sr_clk/sr_data/sr_latch.
// Optional feature macro GPIO_SHIFT_PARITY_EN appends an even-parity bit after the data bits.
module gpio_shift_out #(
    parameter int DATA_W    = 32,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] gpio_in,
    input  logic              refresh,
    output logic              sr_clk,
    output logic              sr_data,
    output logic              sr_latch,
    output logic              busy,
    output logic              done
);

`ifdef GPIO_SHIFT_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int BIT_W = $clog2(NBITS + 1);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shadow_q, shadow_d;
    logic [DATA_W-1:0]   last_q, last_d;
    logic                pend_q, pend_d;
    logic                sr_clk_q, sr_clk_d;
    logic                sr_data_q, sr_data_d;
    logic                sr_latch_q, sr_latch_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start_s;

    // Serial bit at position idx of a transfer; positions past the data carry parity.
    function automatic logic bit_at(input logic [DATA_W-1:0] word, input logic [BIT_W-1:0] idx);
        logic [DATA_W-1:0] mask;
        logic              b;
        mask = {{(DATA_W-1){1'b0}}, 1'b1};
        b    = 1'b0;
        if (idx < BIT_W'(DATA_W)) begin
            if (MSB_FIRST != 0) begin
                mask = mask << (BIT_W'(DATA_W - 1) - idx);
            end else begin
                mask = mask << idx;
            end
            b = |(word & mask);
        end else begin
`ifdef GPIO_SHIFT_PARITY_EN
            b = ^word;
`else
            b = 1'b0;
`endif
        end
        return b;
    endfunction

    assign start_s = (gpio_in != last_q) || pend_q;

    // Next-state and registered-output logic for the transfer sequencer.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shadow_d   = shadow_q;
        last_d     = last_q;
        pend_d     = pend_q | refresh;
        sr_clk_d   = sr_clk_q;
        sr_data_d  = sr_data_q;
        sr_latch_d = sr_latch_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    // A refresh arriving on the start edge is absorbed by this transfer.
                    shadow_d  = gpio_in;
                    last_d    = gpio_in;
                    pend_d    = 1'b0;
                    busy_d    = 1'b1;
                    sr_data_d = bit_at(gpio_in, BIT_W'(0));
                    bit_d     = BIT_W'(0);
                    div_d     = DIV_W'(0);
                    state_d   = SHIFT_LO;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT_LO: begin
                if (div_q == DIV_LAST) begin
                    div_d    = DIV_W'(0);
                    sr_clk_d = 1'b1;
                    state_d  = SHIFT_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_q == DIV_LAST) begin
                    div_d    = DIV_W'(0);
                    sr_clk_d = 1'b0;
                    if (bit_q < BIT_W'(NBITS - 1)) begin
                        bit_d     = bit_q + BIT_W'(1);
                        sr_data_d = bit_at(shadow_q, bit_q + BIT_W'(1));
                        state_d   = SHIFT_LO;
                    end else begin
                        sr_data_d  = 1'b0;
                        sr_latch_d = 1'b1;
                        state_d    = LATCH;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            LATCH: begin
                if (div_q == DIV_LAST) begin
                    div_d      = DIV_W'(0);
                    sr_latch_d = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            div_q      <= DIV_W'(0);
            bit_q      <= BIT_W'(0);
            shadow_q   <= '0;
            last_q     <= '0;
            pend_q     <= 1'b0;
            sr_clk_q   <= 1'b0;
            sr_data_q  <= 1'b0;
            sr_latch_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shadow_q   <= shadow_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            sr_clk_q   <= sr_clk_d;
            sr_data_q  <= sr_data_d;
            sr_latch_q <= sr_latch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sr_clk   = sr_clk_q;
    assign sr_data  = sr_data_q;
    assign sr_latch = sr_latch_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_gpio_shift_out.sv
// Self-checking bench for gpio_shift_out: timeline reference model plus transfer-level literal checks.
// A second instance (8 bits, CLK_DIV=1, LSB first) covers the MSB_FIRST=0 ordering.
module tb_gpio_shift_out;
`ifdef GPIO_SHIFT_PARITY_EN
    localparam int NB       = 33;
    localparam int BUSY_LEN = 268;
    localparam int N2       = 9;
`else
    localparam int NB       = 32;
    localparam int BUSY_LEN = 260;
    localparam int N2       = 8;
`endif
    localparam int D  = 4;
    localparam int SH = 2 * D * NB;
    localparam int TT = SH + D;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] gpio_in = 32'h0;
    logic        refresh = 1'b0;
    logic        sr_clk, sr_data, sr_latch, busy, done;
    logic [7:0]  gin2 = 8'h0;
    logic        refresh2 = 1'b0;
    logic        sr_clk2, sr_data2, sr_latch2, busy2, done2;

    int total = 0;
    int bad   = 0;

    gpio_shift_out dut (
        .clk(clk), .rst(rst), .gpio_in(gpio_in), .refresh(refresh),
        .sr_clk(sr_clk), .sr_data(sr_data), .sr_latch(sr_latch), .busy(busy), .done(done)
    );

    gpio_shift_out #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(0)) dut2 (
        .clk(clk), .rst(rst), .gpio_in(gin2), .refresh(refresh2),
        .sr_clk(sr_clk2), .sr_data(sr_data2), .sr_latch(sr_latch2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: position t along the transfer timeline; t > TT means idle.
    int          t = TT + 1;
    logic [31:0] m_last = 32'h0;
    logic [31:0] m_shadow = 32'h0;
    bit          m_pend = 1'b0;
    bit          started = 1'b0;

    function automatic logic mbit(input logic [31:0] w, input int k);
        if (k >= 32) return ^w;
        return w[31-k];
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst) begin
            t = TT + 1; m_last = 32'h0; m_pend = 1'b0;
        end else if (t < TT) begin
            t++; m_pend = m_pend | refresh;
        end else if (gpio_in != m_last || m_pend) begin
            m_shadow = gpio_in; m_last = gpio_in; m_pend = 1'b0; t = 0;
        end else begin
            m_pend = m_pend | refresh; t = TT + 1;
        end
    end

    // Cycle-by-cycle comparison against the timeline model.
    always @(negedge clk) begin
        logic [4:0] e;
        if (started) begin
            e[4] = (t < TT);
            e[3] = (t < SH) && ((t % (2 * D)) >= D);
            e[2] = (t < SH) ? mbit(m_shadow, t / (2 * D)) : 1'b0;
            e[1] = (t >= SH) && (t < TT);
            e[0] = (t == TT);
            chk("cycle_outputs", {59'h0, busy, sr_clk, sr_data, sr_latch, done}, {59'h0, e});
        end
    end

    // Transfer monitor for the main instance.
    logic [63:0] rx = 64'h0;
    logic        prev_clk = 1'b0;
    int rises_cur = 0, blen_cur = 0, llen_cur = 0, done_cnt = 0;
    logic [31:0] words[$];
    logic        pars[$];
    int          blens[$], risesq[$], llens[$];

    always @(negedge clk) begin
        if (!rst) begin
            rx = 64'h0; rises_cur = 0; blen_cur = 0; llen_cur = 0;
        end else begin
            if (sr_clk && !prev_clk) begin
                rx = {rx[62:0], sr_data}; rises_cur++;
            end
            if (busy) blen_cur++;
            if (sr_latch) llen_cur++;
            if (done) begin
`ifdef GPIO_SHIFT_PARITY_EN
                words.push_back(rx[32:1]); pars.push_back(rx[0]);
`else
                words.push_back(rx[31:0]); pars.push_back(1'b0);
`endif
                blens.push_back(blen_cur); risesq.push_back(rises_cur); llens.push_back(llen_cur);
                done_cnt++;
                rx = 64'h0; rises_cur = 0; blen_cur = 0; llen_cur = 0;
            end
        end
        prev_clk = sr_clk;
    end

    // Transfer monitor for the LSB-first instance.
    logic [8:0] rx2 = 9'h0;
    logic       prev_clk2 = 1'b0;
    logic       first2 = 1'b0;
    int r2 = 0, b2 = 0, done2_cnt = 0;
    logic [7:0] words2[$];
    int         b2q[$];

    always @(negedge clk) begin
        if (!rst) begin
            rx2 = 9'h0; r2 = 0; b2 = 0;
        end else begin
            if (sr_clk2 && !prev_clk2) begin
                if (r2 == 0) first2 = sr_data2;
                rx2 = {sr_data2, rx2[8:1]}; r2++;
            end
            if (busy2) b2++;
            if (done2) begin
`ifdef GPIO_SHIFT_PARITY_EN
                words2.push_back(rx2[7:0]);
`else
                words2.push_back(rx2[8:1]);
`endif
                b2q.push_back(b2); done2_cnt++;
                rx2 = 9'h0; r2 = 0; b2 = 0;
            end
        end
        prev_clk2 = sr_clk2;
    end

    task automatic wait_done(input int n_before, input string nm);
        int c = 0;
        while (done_cnt <= n_before && c < 2000) begin
            step(); c++;
        end
        chk(nm, (done_cnt > n_before) ? 64'd1 : 64'd0, 64'd1);
    endtask

    initial begin
        int n;
        // T1: reset and quiet idle
        rst = 1'b0; gpio_in = 32'h0;
        repeat (3) step();
        chk("t1_reset_outputs", {59'h0, busy, sr_clk, sr_data, sr_latch, done}, 64'h0);
        rst = 1'b1;
        repeat (20) step();
        chk("t1_no_done", done_cnt, 0);
        chk("t1_no_busy", blen_cur, 0);

        // T2/T3: single transfer with coalesced mid-transfer changes
        gpio_in = 32'h12345678; gin2 = 8'h01;
        repeat (50) step();
        gpio_in = 32'hDEADBEEF;
        repeat (50) step();
        gpio_in = 32'hCAFEF00D;
        wait_done(0, "t2_timeout");
        chk("t2_word", words[0], 32'h12345678);
        chk("t2_busy_len", blens[0], BUSY_LEN);
        chk("t2_rises", risesq[0], NB);
        chk("t2_latch_len", llens[0], 4);
        chk("lsb_done", done2_cnt, 1);
        chk("lsb_first_bit", first2, 1'b1);
        chk("lsb_word", words2[0], 8'h01);
        chk("lsb_busy_len", b2q[0], 2 * N2 + 1);
        gin2 = 8'hA5;
        wait_done(1, "t3_timeout");
        chk("t3_word", words[1], 32'hCAFEF00D);
        chk("lsb_word_a5", words2[1], 8'hA5);
        repeat (30) step();
        chk("t3_single_followup", done_cnt, 2);

        // T4: refreshes collapse
        n = done_cnt;
        refresh = 1'b1; step(); step(); refresh = 1'b0;
        repeat (30) step();
        refresh = 1'b1; step(); refresh = 1'b0;
        repeat (40) step();
        refresh = 1'b1; step(); refresh = 1'b0;
        repeat (700) step();
        chk("t4_resend_count", done_cnt, n + 2);
        chk("t4_word", words[$], 32'hCAFEF00D);

        // Randomised traffic, checked cycle by cycle against the model
        for (int i = 0; i < 8; i++) begin
            int len = $urandom_range(40, 400);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 59) == 0) gpio_in = $urandom;
                refresh = ($urandom_range(0, 79) == 0);
                step();
            end
        end
        refresh = 1'b0;
        repeat (700) step();

        // T5: reset at bit 10 aborts; full resend afterwards
        gpio_in = 32'h11111111;
        n = done_cnt;
        wait_done(n, "t5_pre_timeout");
        gpio_in = 32'hDEADBEEF;
        begin
            int c = 0;
            while (rises_cur < 10 && c < 1000) begin step(); c++; end
            chk("t5_reached_bit10", (rises_cur >= 10) ? 64'd1 : 64'd0, 64'd1);
        end
        n = done_cnt;
        rst = 1'b0;
        step();
        chk("t5_outputs_zero", {59'h0, busy, sr_clk, sr_data, sr_latch, done}, 64'h0);
        step();
        rst = 1'b1;
        chk("t5_no_done", done_cnt, n);
        wait_done(n, "t5_timeout");
        chk("t5_word", words[$], 32'hDEADBEEF);
        chk("t5_busy_len", blens[$], BUSY_LEN);

        // T6: parity bit values
        gpio_in = 32'h00000001;
        n = done_cnt;
        wait_done(n, "t6a_timeout");
        chk("t6_word1", words[$], 32'h00000001);
`ifdef GPIO_SHIFT_PARITY_EN
        chk("t6_parity1", pars[$], 1'b1);
`endif
        gpio_in = 32'h00000003;
        n = done_cnt;
        wait_done(n, "t6b_timeout");
        chk("t6_word3", words[$], 32'h00000003);
`ifdef GPIO_SHIFT_PARITY_EN
        chk("t6_parity3", pars[$], 1'b0);
`endif
        chk("t6_busy_len", blens[$], BUSY_LEN);
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
